// File: rtl/chan_rcv.sv
// chan_rcv: deserialises the producer's mix/address byte triplets into
// indexed channel records and buffers them in a show-ahead FIFO.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   sync_stb              frame start: resets sequencer and channel index
//   in_data               producer byte
//   in_stb_mix            in_data is frac / vl / vr
//   in_stb_addr           in_data is addr hi / mid / lo
//   out_valid, out_ready  head-record handshake (pop on valid & ready)
//   out_idx .. out_vr     head record fields
//   err_seq, err_ovf      sticky framing / overflow flags
//   err_clr               clears both sticky flags
`timescale 1ns/1ps

module chan_rcv #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_stb,
  input  logic [7:0]  in_data,
  input  logic        in_stb_mix,
  input  logic        in_stb_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [21:0] out_addr,
  output logic [7:0]  out_frac,
  output logic [5:0]  out_vl,
  output logic [5:0]  out_vr,
  output logic        err_seq,
  output logic        err_ovf,
  input  logic        err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  typedef enum logic [2:0] {
    EXP_FRAC,
    EXP_VL,
    EXP_VR,
    EXP_AHI,
    EXP_AMID,
    EXP_ALO
  } seq_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [21:0] addr;
    logic [7:0]  frac;
    logic [5:0]  vl;
    logic [5:0]  vr;
  } rec_t;

  seq_t       state;
  seq_t       nstate;
  seq_t       st_eff;
  logic [4:0] idx_q;
  logic [4:0] idx_eff;
  logic [4:0] idx_nxt;

  logic [7:0] frac_q;
  logic [5:0] vl_q;
  logic [5:0] vr_q;
  logic [5:0] ahi_q;
  logic [7:0] amid_q;

  logic ld_frac;
  logic ld_vl;
  logic ld_vr;
  logic ld_ahi;
  logic ld_amid;
  logic done;
  logic seq_set;
  logic mix_st;

  logic both;
  logic only_mix;
  logic only_addr;

  rec_t mem [DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  logic full;
  logic push;
  logic pop;
  logic ovf_set;
  rec_t new_rec;
  rec_t head;

  assign both      = in_stb_mix & in_stb_addr;
  assign only_mix  = in_stb_mix & ~in_stb_addr;
  assign only_addr = in_stb_addr & ~in_stb_mix;

  // sync_stb acts before any strobe in the same cycle
  assign st_eff  = sync_stb ? EXP_FRAC : state;
  assign idx_eff = sync_stb ? 5'd0 : idx_q;
  assign mix_st  = (st_eff == EXP_FRAC) ||
                   (st_eff == EXP_VL) ||
                   (st_eff == EXP_VR);

  always_comb begin
    nstate  = st_eff;
    ld_frac = 1'b0;
    ld_vl   = 1'b0;
    ld_vr   = 1'b0;
    ld_ahi  = 1'b0;
    ld_amid = 1'b0;
    done    = 1'b0;
    seq_set = sync_stb && (state != EXP_FRAC);
    unique case (1'b1)
      both: begin
        seq_set = 1'b1;
        nstate  = EXP_FRAC;
      end
      only_mix: begin
        if (mix_st) begin
          unique case (st_eff)
            EXP_FRAC: begin
              ld_frac = 1'b1;
              nstate  = EXP_VL;
            end
            EXP_VL: begin
              ld_vl  = 1'b1;
              nstate = EXP_VR;
            end
            default: begin
              ld_vr  = 1'b1;
              nstate = EXP_AHI;
            end
          endcase
        end else begin
          // restart the record with this byte as frac
          seq_set = 1'b1;
          ld_frac = 1'b1;
          nstate  = EXP_VL;
        end
      end
      only_addr: begin
        if (!mix_st) begin
          unique case (st_eff)
            EXP_AHI: begin
              ld_ahi = 1'b1;
              nstate = EXP_AMID;
            end
            EXP_AMID: begin
              ld_amid = 1'b1;
              nstate  = EXP_ALO;
            end
            default: begin
              done   = 1'b1;
              nstate = EXP_FRAC;
            end
          endcase
        end else begin
          seq_set = 1'b1;
          nstate  = EXP_FRAC;
        end
      end
      default: ;
    endcase
  end

  assign idx_nxt = done ? idx_eff + 5'd1 : idx_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EXP_FRAC;
      idx_q <= 5'd0;
    end else begin
      state <= nstate;
      idx_q <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_q <= 8'd0;
      vl_q   <= 6'd0;
      vr_q   <= 6'd0;
      ahi_q  <= 6'd0;
      amid_q <= 8'd0;
    end else begin
      if (ld_frac) frac_q <= in_data;
      if (ld_vl)   vl_q   <= in_data[5:0];
      if (ld_vr)   vr_q   <= in_data[5:0];
      if (ld_ahi)  ahi_q  <= in_data[5:0];
      if (ld_amid) amid_q <= in_data;
    end
  end

  assign new_rec = '{
    idx:  idx_eff,
    addr: {ahi_q, amid_q, in_data},
    frac: frac_q,
    vl:   vl_q,
    vr:   vr_q
  };

  assign full    = (count == FULL_CNT);
  assign pop     = (count != '0) & out_ready;
  // a pop in the completion cycle frees the slot the push needs
  assign push    = done & (~full | pop);
  assign ovf_set = done & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_seq <= seq_set | (err_seq & ~err_clr);
      err_ovf <= ovf_set | (err_ovf & ~err_clr);
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_idx   = head.idx;
  assign out_addr  = head.addr;
  assign out_frac  = head.frac;
  assign out_vl    = head.vl;
  assign out_vr    = head.vr;

endmodule

// File: tb/tb_chan_rcv.sv
// tb_chan_rcv: table-driven and hand-sequenced checks of chan_rcv
// with a queue scoreboard on the record output.
`timescale 1ns/1ps

module tb_chan_rcv;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_stb;
  logic [7:0]  in_data;
  logic        in_stb_mix;
  logic        in_stb_addr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [21:0] out_addr;
  logic [7:0]  out_frac;
  logic [5:0]  out_vl;
  logic [5:0]  out_vr;
  logic        err_seq;
  logic        err_ovf;
  logic        err_clr;

  always #21 clk = ~clk;

  chan_rcv #(.DEPTH_LOG2(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_stb    (sync_stb),
    .in_data     (in_data),
    .in_stb_mix  (in_stb_mix),
    .in_stb_addr (in_stb_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_addr    (out_addr),
    .out_frac    (out_frac),
    .out_vl      (out_vl),
    .out_vr      (out_vr),
    .err_seq     (err_seq),
    .err_ovf     (err_ovf),
    .err_clr     (err_clr)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [21:0] addr;
    logic [7:0]  frac;
    logic [5:0]  vl;
    logic [5:0]  vr;
  } rec_t;

  typedef struct {
    logic [7:0] f;
    logic [7:0] vl;
    logic [7:0] vr;
    logic [7:0] ahi;
    logic [7:0] amid;
    logic [7:0] alo;
    logic [4:0] idx;
  } vec_t;

  rec_t exp_q[$];
  rec_t got;
  rec_t want;
  vec_t tbl[32];
  bit   exp_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard consumer: a pop happens at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got = {out_idx, out_addr, out_frac, out_vl, out_vr};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rec: got %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        chk("rec", got, want);
      end
    end
  end

  task automatic drv(input logic m, input logic a,
                     input logic s, input logic c,
                     input logic [7:0] d);
    in_stb_mix  = m;
    in_stb_addr = a;
    sync_stb    = s;
    err_clr     = c;
    in_data     = d;
    @(posedge clk);
    #1;
    in_stb_mix  = 1'b0;
    in_stb_addr = 1'b0;
    sync_stb    = 1'b0;
    err_clr     = 1'b0;
    in_data     = 8'h00;
  endtask

  // called during the completion cycle, before its falling edge
  task automatic push_exp(input rec_t r);
    bit pop_now;
    pop_now = out_ready && (exp_q.size() > 0);
    if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(r);
    else exp_ovf = 1'b1;
  endtask

  function automatic rec_t mk(input logic [7:0] f,
                              input logic [7:0] vl,
                              input logic [7:0] vr,
                              input logic [7:0] ahi,
                              input logic [7:0] amid,
                              input logic [7:0] alo,
                              input logic [4:0] idx);
    rec_t r;
    r.idx  = idx;
    r.addr = {ahi[5:0], amid, alo};
    r.frac = f;
    r.vl   = vl[5:0];
    r.vr   = vr[5:0];
    return r;
  endfunction

  task automatic send_rec(input logic [7:0] f,
                          input logic [7:0] vl,
                          input logic [7:0] vr,
                          input logic [7:0] ahi,
                          input logic [7:0] amid,
                          input logic [7:0] alo,
                          input logic [4:0] idx,
                          input bit pop_last);
    drv(1, 0, 0, 0, f);
    drv(1, 0, 0, 0, vl);
    drv(1, 0, 0, 0, vr);
    drv(0, 1, 0, 0, ahi);
    drv(0, 1, 0, 0, amid);
    if (pop_last) out_ready = 1'b1;
    push_exp(mk(f, vl, vr, ahi, amid, alo, idx));
    drv(0, 1, 0, 0, alo);
    if (pop_last) out_ready = 1'b0;
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_empty"}, out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_seq", err_seq, 0);
    chk("rst_ovf", err_ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    sync_stb    = 1'b0;
    in_data     = 8'h00;
    in_stb_mix  = 1'b0;
    in_stb_addr = 1'b0;
    out_ready   = 1'b0;
    err_clr     = 1'b0;
    exp_ovf     = 1'b0;

    for (int i = 0; i < 32; i++) begin
      tbl[i].f    = 8'(i * 37 + 5);
      tbl[i].vl   = 8'(i * 11 + 8'hC0);
      tbl[i].vr   = 8'(255 - i * 5);
      tbl[i].ahi  = 8'(i * 29 + 1);
      tbl[i].amid = 8'(i * 53);
      tbl[i].alo  = 8'(i * 97 + 3);
      tbl[i].idx  = 5'(i);
    end

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single record, idle gaps, latency of one clock
    drv(0, 0, 1, 0, 8'h00);
    chk("sync_in_frac_no_err", err_seq, 0);
    drv(1, 0, 0, 0, 8'h5A);
    drv(0, 0, 0, 0, 8'h00);
    drv(1, 0, 0, 0, 8'h3F);
    drv(1, 0, 0, 0, 8'h01);
    drv(0, 0, 0, 0, 8'h00);
    drv(0, 1, 0, 0, 8'h2A);
    drv(0, 1, 0, 0, 8'hBC);
    push_exp(mk(8'h5A, 8'h3F, 8'h01, 8'h2A, 8'hBC, 8'hDE, 5'd0));
    in_stb_addr = 1'b1;
    in_data     = 8'hDE;
    @(negedge clk);
    chk("lat_before", out_valid, 0);
    @(posedge clk);
    #1;
    in_stb_addr = 1'b0;
    chk("lat_after", out_valid, 1);
    chk("single_addr", out_addr, 22'h2ABCDE);
    chk("single_seq", err_seq, 0);
    chk("single_ovf", err_ovf, 0);
    drain("single");

    // full frame from the table, consumer always ready, then wrap
    drv(0, 0, 1, 0, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++)
      send_rec(tbl[i].f, tbl[i].vl, tbl[i].vr, tbl[i].ahi,
               tbl[i].amid, tbl[i].alo, tbl[i].idx, 0);
    send_rec(8'h81, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 5'd0, 0);
    drain("frame");
    chk("frame_seq", err_seq, 0);
    chk("frame_ovf", err_ovf, 0);

    // backpressure: 4 retained, 5th dropped, 6th pushed with a pop
    drv(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      send_rec(8'(8'h20 + i), 8'h11, 8'h22, 8'h33,
               8'(8'h40 + i), 8'(8'h50 + i), 5'(i), 0);
    chk("bp_ovf", err_ovf, exp_ovf);
    chk("bp_ovf_set", err_ovf, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_idx, 0);
    drv(0, 0, 0, 1, 8'h00);
    chk("bp_clr", err_ovf, 0);
    send_rec(8'h66, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 5'd5, 1);
    chk("bp_pop_push_ovf", err_ovf, 0);
    drain("bp");

    // sequence errors
    drv(0, 0, 1, 0, 8'h00);
    drv(1, 0, 0, 0, 8'h11);
    drv(1, 0, 0, 0, 8'h22);
    drv(0, 1, 0, 0, 8'h33);
    chk("addr_in_vl", err_seq, 1);
    chk("addr_in_vl_norec", out_valid, 0);
    drv(0, 0, 0, 1, 8'h00);
    chk("clr_seq", err_seq, 0);
    send_rec(8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 5'd0, 0);
    chk("recover_seq", err_seq, 0);
    drv(1, 0, 0, 0, 8'h91);
    drv(1, 0, 0, 0, 8'h92);
    drv(1, 0, 0, 0, 8'h93);
    drv(0, 1, 0, 0, 8'h94);
    send_rec(8'h77, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 5'd1, 0);
    chk("mix_in_amid", err_seq, 1);
    drv(0, 0, 0, 1, 8'h00);
    drv(1, 1, 0, 0, 8'h99);
    chk("both_strobes", err_seq, 1);
    send_rec(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 5'd2, 0);
    drv(0, 0, 0, 1, 8'h00);
    drv(0, 1, 0, 1, 8'h44);
    chk("set_beats_clr", err_seq, 1);
    drain("seq");

    // sync mid-record keeps the FIFO, restarts index
    drv(0, 0, 0, 1, 8'h00);
    send_rec(8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 5'd3, 0);
    drv(1, 0, 0, 0, 8'hC1);
    drv(1, 0, 0, 0, 8'hC2);
    drv(0, 0, 1, 0, 8'h00);
    chk("sync_mid", err_seq, 1);
    send_rec(8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 5'd0, 0);
    drv(0, 0, 0, 1, 8'h00);
    drv(1, 0, 0, 0, 8'hE1);
    drv(1, 0, 1, 0, 8'h33);
    chk("sync_with_mix", err_seq, 1);
    drv(1, 0, 0, 0, 8'hE2);
    drv(1, 0, 0, 0, 8'hE3);
    drv(0, 1, 0, 0, 8'hE4);
    drv(0, 1, 0, 0, 8'hE5);
    push_exp(mk(8'h33, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 5'd0));
    drv(0, 1, 0, 0, 8'hE6);
    drain("sync");

    // reset mid-record
    drv(0, 0, 0, 1, 8'h00);
    send_rec(8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 5'd1, 0);
    drv(0, 1, 0, 0, 8'h00);
    chk("pre_rst_seq", err_seq, 1);
    drv(1, 0, 0, 0, 8'h55);
    do_reset();
    send_rec(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 5'd0, 0);
    chk("post_rst_seq", err_seq, 0);
    drain("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
